// File: rtl/cmul_pkt_arbiter_if.sv
// Bundled stream signals for the complex-multiplier packet arbiter.
// The arbiter uses the slave modport; its environment (requesters, multiplier, sinks) uses master.
interface cmul_pkt_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int PWIDTH     = 2 * DATA_WIDTH
);
    logic [2*DATA_WIDTH-1:0] s0_adata;
    logic [2*DATA_WIDTH-1:0] s0_bdata;
    logic                    s0_tvalid;
    logic                    s0_tlast;
    logic                    s0_tready;
    logic [2*DATA_WIDTH-1:0] s1_adata;
    logic [2*DATA_WIDTH-1:0] s1_bdata;
    logic                    s1_tvalid;
    logic                    s1_tlast;
    logic                    s1_tready;

    logic [2*DATA_WIDTH-1:0] m_adata;
    logic [2*DATA_WIDTH-1:0] m_bdata;
    logic                    m_tvalid;
    logic                    m_tlast;
    logic                    m_tready;

    logic [2*PWIDTH-1:0]     r_tdata;
    logic                    r_tvalid;
    logic                    r_tlast;
    logic                    r_tready;

    logic [2*PWIDTH-1:0]     o0_tdata;
    logic                    o0_tvalid;
    logic                    o0_tlast;
    logic                    o0_tready;
    logic [2*PWIDTH-1:0]     o1_tdata;
    logic                    o1_tvalid;
    logic                    o1_tlast;
    logic                    o1_tready;

    modport slave (
        input  s0_adata, s0_bdata, s0_tvalid, s0_tlast,
        output s0_tready,
        input  s1_adata, s1_bdata, s1_tvalid, s1_tlast,
        output s1_tready,
        output m_adata, m_bdata, m_tvalid, m_tlast,
        input  m_tready,
        input  r_tdata, r_tvalid, r_tlast,
        output r_tready,
        output o0_tdata, o0_tvalid, o0_tlast,
        input  o0_tready,
        output o1_tdata, o1_tvalid, o1_tlast,
        input  o1_tready
    );

    modport master (
        output s0_adata, s0_bdata, s0_tvalid, s0_tlast,
        input  s0_tready,
        output s1_adata, s1_bdata, s1_tvalid, s1_tlast,
        input  s1_tready,
        input  m_adata, m_bdata, m_tvalid, m_tlast,
        output m_tready,
        output r_tdata, r_tvalid, r_tlast,
        input  r_tready,
        input  o0_tdata, o0_tvalid, o0_tlast,
        output o0_tready,
        input  o1_tdata, o1_tvalid, o1_tlast,
        output o1_tready
    );
endinterface

// File: rtl/cmul_pkt_arbiter.sv
// Two-port packet arbiter in front of a shared complex multiplier; a tag FIFO routes results back.
// Define CMUL_ARB_RR_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module cmul_pkt_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int PWIDTH     = 2 * DATA_WIDTH,
    parameter int TAG_DEPTH  = 8,
    localparam int PTR_W     = $clog2(TAG_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    cmul_pkt_arbiter_if.slave    bus,
    output logic [CNT_W-1:0]     inflight
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    tag_mem_q [TAG_DEPTH];

    logic [2*DATA_WIDTH-1:0] s_adata [2];
    logic [2*DATA_WIDTH-1:0] s_bdata [2];
    logic [1:0]              s_tvalid;
    logic [1:0]              s_tlast;
    logic [1:0]              s_tready;
    logic [1:0]              o_tvalid;
    logic [1:0]              o_tready;

    logic [2*DATA_WIDTH-1:0] m_adata;
    logic [2*DATA_WIDTH-1:0] m_bdata;
    logic                    m_tvalid;
    logic                    m_tlast;

    logic                    owner;
    logic                    grant_sel;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    head_tag;
    logic                    r_tready;

    assign s_adata[0]  = bus.s0_adata;
    assign s_bdata[0]  = bus.s0_bdata;
    assign s_tvalid[0] = bus.s0_tvalid;
    assign s_tlast[0]  = bus.s0_tlast;
    assign s_adata[1]  = bus.s1_adata;
    assign s_bdata[1]  = bus.s1_bdata;
    assign s_tvalid[1] = bus.s1_tvalid;
    assign s_tlast[1]  = bus.s1_tlast;
    assign bus.s0_tready = s_tready[0];
    assign bus.s1_tready = s_tready[1];

    assign bus.m_adata  = m_adata;
    assign bus.m_bdata  = m_bdata;
    assign bus.m_tvalid = m_tvalid;
    assign bus.m_tlast  = m_tlast;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign head_tag   = tag_mem_q[rd_ptr_q];
    assign owner      = (state_q == GRANT1);
    assign inflight   = count_q;

    // ---------------------------------------------------------------- selection
`ifdef CMUL_ARB_RR_EN
    logic last_q, last_d;

    // On a tie the port that did not win last time goes next.
    assign grant_sel = (s_tvalid[0] && s_tvalid[1]) ? ~last_q : ~s_tvalid[0];
    assign last_d    = push ? grant_sel : last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign grant_sel = ~s_tvalid[0];
`endif

    // ---------------------------------------------------------------- packet FSM
    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        m_adata  = '0;
        m_bdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = 2'b00;
        unique case (state_q)
            IDLE: begin
                if ((|s_tvalid) && !fifo_full) begin
                    push    = 1'b1;
                    state_d = grant_sel ? GRANT1 : GRANT0;
                end
            end
            GRANT0, GRANT1: begin
                m_adata         = s_adata[owner];
                m_bdata         = s_bdata[owner];
                m_tvalid        = s_tvalid[owner];
                m_tlast         = s_tlast[owner];
                s_tready[owner] = bus.m_tready;
                if (s_tvalid[owner] && bus.m_tready && s_tlast[owner]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- tag FIFO
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= grant_sel;
        end
    end

    // ---------------------------------------------------------------- result routing
    assign o_tready[0] = bus.o0_tready;
    assign o_tready[1] = bus.o1_tready;
    assign r_tready    = !fifo_empty && o_tready[head_tag];
    assign pop         = bus.r_tvalid && r_tready && bus.r_tlast;
    assign bus.r_tready = r_tready;

    for (genvar gi = 0; gi < 2; gi++) begin : g_route
        assign o_tvalid[gi] = !fifo_empty && (int'(head_tag) == gi) && bus.r_tvalid;
    end

    assign bus.o0_tvalid = o_tvalid[0];
    assign bus.o1_tvalid = o_tvalid[1];
    assign bus.o0_tdata  = bus.r_tdata;
    assign bus.o1_tdata  = bus.r_tdata;
    assign bus.o0_tlast  = bus.r_tlast;
    assign bus.o1_tlast  = bus.r_tlast;

endmodule
